// File: rtl/clock_divider_prog.sv
// Programmable multi-channel clock-enable generator: per-channel divisor, run/step
// control, one-cycle tick and registered square wave, plus an LED tick counter.
module clock_divider_prog #(
  parameter int NUM_CH           = 2,
  parameter int WIDTH            = 32,
  parameter int LED_W            = 4,
  parameter int DEFAULT_DIV_FAST = 64,
  parameter int DEFAULT_DIV_SLOW = 33554432
) (
  input  logic                    fast_clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       step,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] div_in,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [LED_W-1:0]        ledr
);

  localparam logic [WIDTH-1:0] DEF_FAST = WIDTH'(DEFAULT_DIV_FAST);
  localparam logic [WIDTH-1:0] DEF_SLOW = WIDTH'(DEFAULT_DIV_SLOW);

  // Divisors below 2 cannot form a period with a high and a low phase.
  function automatic logic [WIDTH-1:0] sat_div(input logic [WIDTH-1:0] d);
    return (d >= WIDTH'(2)) ? d : WIDTH'(2);
  endfunction

  logic [LED_W-1:0] led_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] n_eff;
    logic [WIDTH-1:0] cnt_nxt;
    logic             clk_q;
    logic             adv;

    assign n_eff   = sat_div(div_q);
    assign adv     = en[c] | step[c];
    assign tick[c] = adv & (cnt == n_eff - WIDTH'(1));
    // An out-of-range count also returns to 0, but only the exact wrap ticks.
    assign cnt_nxt = (cnt >= n_eff - WIDTH'(1)) ? '0 : cnt + WIDTH'(1);

    // Channel state update
    always_ff @(posedge fast_clock) begin
      if (reset) begin
        div_q <= (c == 0) ? DEF_FAST : DEF_SLOW;
        cnt   <= '0;
        clk_q <= 1'b0;
      end else if (load[c]) begin
        div_q <= div_in[c*WIDTH +: WIDTH];
        cnt   <= '0;
        clk_q <= 1'b0;
      end else if (adv) begin
        cnt   <= cnt_nxt;
        clk_q <= (cnt_nxt >= (n_eff >> 1));
      end
    end

    assign clk_out[c] = clk_q;
  end

  // LED activity counter on the last channel
  always_ff @(posedge fast_clock) begin
    if (reset)
      led_q <= '0;
    else if (tick[NUM_CH-1])
      led_q <= led_q + LED_W'(1);
  end

  assign ledr = led_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: default divisors, loads, clamping,
// single-step, load-in-wrap and mid-period reset.
module tb_clock_divider_prog;

  logic        fast_clock = 1'b0;
  logic        reset;
  logic [1:0]  en;
  logic [1:0]  step;
  logic [1:0]  load;
  logic [63:0] div_in;
  logic [1:0]  tick;
  logic [1:0]  clk_out;
  logic [3:0]  ledr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 fast_clock = ~fast_clock;

  clock_divider_prog dut (
    .fast_clock (fast_clock),
    .reset      (reset),
    .en         (en),
    .step       (step),
    .load       (load),
    .div_in     (div_in),
    .tick       (tick),
    .clk_out    (clk_out),
    .ledr       (ledr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge fast_clock);
    #1;
  endtask

  task automatic load_div(input int ch, input logic [31:0] d);
    load = 2'b00;
    load[ch] = 1'b1;
    div_in[ch*32 +: 32] = d;
    next_cyc();
    load = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    en     = 2'b00;
    step   = 2'b00;
    load   = 2'b00;
    div_in = '0;
    next_cyc();
    next_cyc();
    @(negedge fast_clock);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_led", 32'(ledr), 0);
    next_cyc();

    // Default divisor 64 on channel 0, channel 1 idle
    reset = 1'b0;
    en    = 2'b01;
    for (int i = 0; i < 200; i++) begin
      @(negedge fast_clock);
      chk($sformatf("t1_tick0[%0d]", i), 32'(tick[0]), 32'((i % 64) == 63));
      chk($sformatf("t1_clk0[%0d]", i), 32'(clk_out[0]), 32'((i % 64) >= 32));
      chk($sformatf("t1_tick1[%0d]", i), 32'(tick[1]), 0);
      chk($sformatf("t1_clk1[%0d]", i), 32'(clk_out[1]), 0);
      next_cyc();
    end

    // Channel 1 divide by 5, LED counter wraps after 16 ticks
    en = 2'b00;
    load_div(1, 5);
    en = 2'b10;
    for (int j = 0; j < 85; j++) begin
      @(negedge fast_clock);
      chk($sformatf("t2_tick1[%0d]", j), 32'(tick[1]), 32'((j % 5) == 4));
      chk($sformatf("t2_clk1[%0d]", j), 32'(clk_out[1]), 32'((j % 5) >= 2));
      chk($sformatf("t2_led[%0d]", j), 32'(ledr), 32'((j / 5) % 16));
      chk($sformatf("t2_tick0[%0d]", j), 32'(tick[0]), 0);
      next_cyc();
    end

    // Divisors 0 and 1 clamp to 2
    for (int d = 0; d < 2; d++) begin
      en = 2'b00;
      load_div(0, 32'(d));
      en = 2'b01;
      for (int j = 0; j < 8; j++) begin
        @(negedge fast_clock);
        chk($sformatf("t3_d%0d_tick0[%0d]", d, j), 32'(tick[0]), 32'((j % 2) == 1));
        chk($sformatf("t3_d%0d_clk0[%0d]", d, j), 32'(clk_out[0]), 32'(j % 2));
        next_cyc();
      end
    end

    // Single-step with en low, divisor 4
    en = 2'b00;
    load_div(0, 4);
    for (int k = 0; k < 4; k++) begin
      step = 2'b01;
      @(negedge fast_clock);
      chk($sformatf("t4_step_tick[%0d]", k), 32'(tick[0]), 32'(k == 3));
      chk($sformatf("t4_step_clk[%0d]", k), 32'(clk_out[0]), 32'(k >= 2));
      next_cyc();
      step = 2'b00;
      for (int w = 0; w < 2; w++) begin
        @(negedge fast_clock);
        chk($sformatf("t4_idle_tick[%0d.%0d]", k, w), 32'(tick[0]), 0);
        chk($sformatf("t4_idle_clk[%0d.%0d]", k, w), 32'(clk_out[0]), 32'(((k + 1) % 4) >= 2));
        next_cyc();
      end
    end

    // step held together with en: no extra advance
    en   = 2'b01;
    step = 2'b01;
    for (int j = 0; j < 8; j++) begin
      @(negedge fast_clock);
      chk($sformatf("t4_en_step_tick[%0d]", j), 32'(tick[0]), 32'((j % 4) == 3));
      chk($sformatf("t4_en_step_clk[%0d]", j), 32'(clk_out[0]), 32'((j % 4) >= 2));
      next_cyc();
    end

    // Load of divisor 3 in the wrap cycle of N=4
    step = 2'b00;
    for (int j = 0; j < 3; j++) begin
      @(negedge fast_clock);
      chk($sformatf("t5_pre_tick[%0d]", j), 32'(tick[0]), 0);
      next_cyc();
    end
    load = 2'b01;
    div_in[31:0] = 32'd3;
    @(negedge fast_clock);
    chk("t5_wrap_tick", 32'(tick[0]), 1);
    next_cyc();
    load = 2'b00;
    for (int j = 0; j < 6; j++) begin
      @(negedge fast_clock);
      chk($sformatf("t5_post_tick[%0d]", j), 32'(tick[0]), 32'((j % 3) == 2));
      chk($sformatf("t5_post_clk[%0d]", j), 32'(clk_out[0]), 32'((j % 3) >= 1));
      next_cyc();
    end

    // Reset mid-period restores defaults
    en = 2'b00;
    load_div(0, 64);
    en = 2'b11;
    for (int j = 0; j < 40; j++) begin
      @(negedge fast_clock);
      chk($sformatf("t6_run_tick0[%0d]", j), 32'(tick[0]), 0);
      next_cyc();
    end
    @(negedge fast_clock);
    chk("t6_clk_pre", 32'(clk_out[0]), 1);
    chk("t6_led_pre", 32'(ledr), 9);
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    for (int j = 0; j < 70; j++) begin
      @(negedge fast_clock);
      chk($sformatf("t6_tick0[%0d]", j), 32'(tick[0]), 32'(j == 63));
      chk($sformatf("t6_clk0[%0d]", j), 32'(clk_out[0]), 32'((j % 64) >= 32));
      chk($sformatf("t6_tick1[%0d]", j), 32'(tick[1]), 0);
      chk($sformatf("t6_clk1[%0d]", j), 32'(clk_out[1]), 0);
      chk($sformatf("t6_led[%0d]", j), 32'(ledr), 0);
      next_cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
